// File: rtl/vga_pkg.sv
// Shared constants and scheduler state encoding for the VRAM access path.
// Frame geometry, pixel/address widths and the sched_st_e enum.
package vga_pkg;

  localparam int unsigned H_PIX     = 128;
  localparam int unsigned V_PIX     = 96;
  localparam int unsigned FRAME_PIX = H_PIX * V_PIX;
  localparam int unsigned DATA_W    = 3;
  localparam int unsigned ADDR_W    = 14;
  localparam int unsigned RC_W      = 7;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DISP_RD = 2'd1,
    S_HOST_WR = 2'd2,
    S_HOST_RD = 2'd3
  } sched_st_e;

endpackage

// File: rtl/vram_addr_calc.sv
// Scaled row/col to linear VRAM address plus in-range flag (combinational).
// Ports: i_row, i_col in; o_addr = row*H_PIX+col (shift/or), o_ok = in frame.
module vram_addr_calc
  import vga_pkg::*;
(
  input  logic [RC_W-1:0]   i_row,
  input  logic [RC_W-1:0]   i_col,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_ok
);

  localparam int unsigned SH = $clog2(H_PIX);

  logic w_row_ok;
  logic w_col_ok;

  // H_PIX is a power of two, so row*H_PIX+col is a shift and an or.
  assign o_addr = ADDR_W'((32'(i_row) << SH) | 32'(i_col));

  assign w_row_ok = 32'(i_row) < V_PIX;
  assign w_col_ok = 32'(i_col) < H_PIX;
  assign o_ok     = w_row_ok & w_col_ok;

endmodule

// File: rtl/vram_access_scheduler.sv
// Single-port VRAM arbiter: display fetch always wins, host uses free slots.
// Ports: clk/reset, disp_* fetch, host_* valid/ready port, mem_* VRAM side.
// Optional macro HOST_READ_EN enables host reads (else host is write-only).
module vram_access_scheduler
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [RC_W-1:0]   disp_row,
  input  logic [RC_W-1:0]   disp_col,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              host_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  sched_st_e         r_state;
  sched_st_e         w_nxt;
  logic [ADDR_W-1:0] w_disp_addr;
  logic [ADDR_W-1:0] w_nxt_addr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] w_nxt_wdata;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              w_disp_ok;
  logic              w_host_ok;
  logic              w_nxt_ok;
  logic              r_mem_en;
  logic              r_mem_we;
  logic              r_ok;
  logic              r_rsp_disp;
  logic              r_rsp_ok;
  logic              r_err;

  vram_addr_calc u_calc (
    .i_row  (disp_row),
    .i_col  (disp_col),
    .o_addr (w_disp_addr),
    .o_ok   (w_disp_ok)
  );

  assign w_host_ok  = 32'(host_addr) < FRAME_PIX;
  assign host_ready = ~disp_req & ~reset;

  always_comb begin
    w_nxt       = S_IDLE;
    w_nxt_addr  = r_mem_addr;
    w_nxt_wdata = r_mem_wdata;
    w_nxt_ok    = 1'b0;
    unique case (1'b1)
      disp_req: begin
        w_nxt      = S_DISP_RD;
        w_nxt_addr = w_disp_addr;
        w_nxt_ok   = w_disp_ok;
      end
      (~disp_req & host_valid): begin
`ifdef HOST_READ_EN
        w_nxt = host_we ? S_HOST_WR : S_HOST_RD;
`else
        w_nxt = S_HOST_WR;
`endif
        w_nxt_addr  = host_addr;
        w_nxt_wdata = host_wdata;
        w_nxt_ok    = w_host_ok;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_ok        <= 1'b0;
      r_rsp_disp  <= 1'b0;
      r_rsp_ok    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_mem_en    <= (w_nxt != S_IDLE) & w_nxt_ok;
      r_mem_we    <= (w_nxt == S_HOST_WR) & w_nxt_ok;
      r_mem_addr  <= w_nxt_addr;
      r_mem_wdata <= w_nxt_wdata;
      r_ok        <= w_nxt_ok;
      // Response tag: what the VRAM returns next cycle belongs to.
      r_rsp_disp  <= r_state == S_DISP_RD;
      r_rsp_ok    <= r_ok;
      if (host_valid & host_ready & ~w_host_ok)
        r_err <= 1'b1;
    end
  end

  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign host_err   = r_err;
  assign disp_valid = r_rsp_disp;
  // Out-of-range fetches never touched the VRAM: return black.
  assign disp_data  = (r_rsp_disp & r_rsp_ok) ? mem_rdata : '0;

`ifdef HOST_READ_EN
  logic r_rsp_host;

  always_ff @(posedge clk) begin
    if (reset)
      r_rsp_host <= 1'b0;
    else
      r_rsp_host <= r_state == S_HOST_RD;
  end

  assign host_rvalid = r_rsp_host;
  assign host_rdata  = (r_rsp_host & r_rsp_ok) ? mem_rdata : '0;
`else
  logic w_unused_we;

  assign w_unused_we = host_we;
  assign host_rvalid = 1'b0;
  assign host_rdata  = '0;
`endif

endmodule

// File: tb/tb_vram_access_scheduler.sv
// Directed bench for vram_access_scheduler with a behavioural VRAM model.
// Honours HOST_READ_EN the same way as the design.
module tb_vram_access_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        disp_req;
  logic [6:0]  disp_row;
  logic [6:0]  disp_col;
  logic [2:0]  disp_data;
  logic        disp_valid;
  logic        host_valid;
  logic        host_ready;
  logic        host_we;
  logic [13:0] host_addr;
  logic [2:0]  host_wdata;
  logic [2:0]  host_rdata;
  logic        host_rvalid;
  logic        host_err;
  logic        mem_en;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [2:0]  mem_wdata;
  logic [2:0]  mem_rdata = 3'd0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vram_access_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .disp_req    (disp_req),
    .disp_row    (disp_row),
    .disp_col    (disp_col),
    .disp_data   (disp_data),
    .disp_valid  (disp_valid),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_rdata  (host_rdata),
    .host_rvalid (host_rvalid),
    .host_err    (host_err),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  // Synchronous single-port VRAM, preloaded with ram[i] = i mod 8.
  logic [2:0] ram [16384];
  logic [2:0] mdl [16384];

  initial begin
    for (int i = 0; i < 16384; i++) begin
      ram[i] = 3'(i);
      mdl[i] = 3'(i);
    end
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected state: stage 1 = VRAM command, stage 2 = response.
  int          cyc = 0;
  logic        e_rst = 1'b1;
  logic        e1_en = 1'b0;
  logic        e1_we = 1'b0;
  logic        e1_ok = 1'b0;
  int          e1_kind = 0;
  int          e1_addr = 0;
  int          e1_wd = 0;
  logic        e2_dv = 1'b0;
  logic        e2_hv = 1'b0;
  int          e2_val = 0;
  logic        e_err = 1'b0;
  logic        e_rdy;
  int          n_rv = 0;
  int          rv_dat [$];
  int          rv_cyc [$];
  int          n_hg = 0;
  int          n_we = 0;

  always @(posedge clk) begin
    logic s_rst, s_dq, s_hv, s_we, wr;
    int   ra, ha;
    s_rst = reset;
    s_dq  = disp_req;
    s_hv  = host_valid;
    s_we  = host_we;
    ha    = int'(host_addr);
    ra    = int'(disp_row) * 128 + int'(disp_col);
    if (s_hv && host_ready) n_hg++;
    e_rdy = !s_rst && !s_dq;
    if (s_rst) begin
      e_rst = 1'b1;
      e1_en = 0; e1_we = 0; e1_ok = 0;
      e1_kind = 0; e1_addr = 0; e1_wd = 0;
      e2_dv = 0; e2_hv = 0; e2_val = 0;
      e_err = 0;
    end else begin
      e_rst  = 1'b0;
      e2_dv  = (e1_kind == 1);
      e2_hv  = (e1_kind == 2);
      e2_val = e1_ok ? int'(mdl[e1_addr]) : 0;
      e1_kind = 0; e1_en = 0; e1_we = 0; e1_ok = 0;
      if (s_dq) begin
        e1_kind = 1;
        e1_addr = ra;
        e1_ok   = (disp_row < 96) && (disp_col < 128);
        e1_en   = e1_ok;
      end else if (s_hv) begin
`ifdef HOST_READ_EN
        wr = s_we;
`else
        wr = 1'b1;
`endif
        e1_kind = wr ? 0 : 2;
        e1_addr = ha;
        e1_wd   = int'(host_wdata);
        e1_ok   = ha < 12288;
        e1_en   = e1_ok;
        e1_we   = e1_ok && wr;
        if (e1_ok && wr) mdl[ha] = host_wdata;
        if (!e1_ok) e_err = 1'b1;
      end
    end
    #1;
    cyc++;
    chk("host_ready", host_ready, e_rdy);
    chk("mem_en", mem_en, e1_en);
    chk("mem_we", mem_we, e1_we);
    chk("disp_valid", disp_valid, e2_dv);
    chk("host_rvalid", host_rvalid, e2_hv);
    chk("host_err", host_err, e_err);
    if (e1_en) chk("mem_addr", mem_addr, e1_addr);
    if (e1_we) chk("mem_wdata", mem_wdata, e1_wd);
    if (e_rst) begin
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
    end
    if (e2_dv || e_rst) chk("disp_data", disp_data, e2_dv ? e2_val : 0);
    if (e2_hv || e_rst) chk("host_rdata", host_rdata, e2_hv ? e2_val : 0);
    if (mem_we) n_we++;
    if (host_rvalid) begin
      n_rv++;
      rv_dat.push_back(int'(host_rdata));
      rv_cyc.push_back(cyc);
    end
  end

  task automatic drv(input logic rst, input logic dq,
                     input logic [6:0] row, input logic [6:0] col,
                     input logic hv, input logic we,
                     input logic [13:0] a, input logic [2:0] wd);
    @(negedge clk);
    reset      = rst;
    disp_req   = dq;
    disp_row   = row;
    disp_col   = col;
    host_valid = hv;
    host_we    = we;
    host_addr  = a;
    host_wdata = wd;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 14'd0, 3'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; disp_req = 1'b0; disp_row = '0; disp_col = '0;
    host_valid = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    drv(1'b1, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 14'd0, 3'd0);
    tick(); tick();
    chk("rst_en", mem_en, 0);
    chk("rst_err", host_err, 0);

    // Reset while a display read is in flight.
    drv(1'b0, 1'b1, 7'd2, 7'd3, 1'b0, 1'b0, 14'd0, 3'd0);
    tick();
    chk("t1_addr", mem_addr, 259);
    chk("t1_en", mem_en, 1);
    drv(1'b1, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 14'd0, 3'd0);
    tick();
    chk("t1_dvalid", disp_valid, 0);
    chk("t1_en_off", mem_en, 0);
    chk("t1_addr_clr", mem_addr, 0);

    // Display read row 1 col 5.
    drv(1'b0, 1'b1, 7'd1, 7'd5, 1'b0, 1'b0, 14'd0, 3'd0);
    tick();
    chk("t2_addr", mem_addr, 133);
    chk("t2_en", mem_en, 1);
    idle();
    tick();
    chk("t2_dvalid", disp_valid, 1);
    chk("t2_ddata", disp_data, 5);

    // Collision: display wins, host served next cycle.
    drv(1'b0, 1'b1, 7'd0, 7'd7, 1'b1, 1'b1, 14'd200, 3'd6);
    #1 chk("t3_rdy0", host_ready, 0);
    tick();
    drv(1'b0, 1'b0, 7'd0, 7'd0, 1'b1, 1'b1, 14'd200, 3'd6);
    #1 chk("t3_rdy1", host_ready, 1);
    tick();
    chk("t3_we", mem_we, 1);
    chk("t3_addr", mem_addr, 200);
    chk("t3_wdata", mem_wdata, 6);
    idle();

    // Out-of-range display and host accesses.
    drv(1'b0, 1'b1, 7'd96, 7'd0, 1'b0, 1'b0, 14'd0, 3'd0);
    tick();
    chk("t4_en", mem_en, 0);
    idle();
    tick();
    chk("t4_dvalid", disp_valid, 1);
    chk("t4_black", disp_data, 0);
    drv(1'b0, 1'b0, 7'd0, 7'd0, 1'b1, 1'b1, 14'd12288, 3'd7);
    tick();
    chk("t4_hen", mem_en, 0);
    chk("t4_err", host_err, 1);
    idle();
    tick(); tick();
    chk("t4_err_sticky", host_err, 1);

    // Back-to-back writes then reads.
    n_rv = 0;
    rv_dat.delete();
    rv_cyc.delete();
    for (int i = 0; i < 4; i++)
      drv(1'b0, 1'b0, 7'd0, 7'd0, 1'b1, 1'b1, 14'(i), 3'(7 - i));
    for (int i = 0; i < 4; i++)
      drv(1'b0, 1'b0, 7'd0, 7'd0, 1'b1, 1'b0, 14'(i), 3'd0);
    idle();
    repeat (4) tick();
`ifdef HOST_READ_EN
    chk("t5_nrv", n_rv, 4);
    if (n_rv == 4) begin
      for (int i = 0; i < 4; i++) chk("t5_rdata", rv_dat[i], 7 - i);
      chk("t5_consec", rv_cyc[3] - rv_cyc[0], 3);
    end
`else
    chk("t5_nrv", n_rv, 0);
`endif

    // Display starves a held host request for 10 cycles.
    n_hg = 0;
    n_we = 0;
    for (int i = 0; i < 10; i++) begin
      drv(1'b0, 1'b1, 7'd3, 7'(i), 1'b1, 1'b1, 14'd300, 3'd2);
      #1 chk("t6_rdy0", host_ready, 0);
    end
    drv(1'b0, 1'b0, 7'd0, 7'd0, 1'b1, 1'b1, 14'd300, 3'd2);
    #1 chk("t6_rdy1", host_ready, 1);
    idle();
    tick(); tick();
    chk("t6_grants", n_hg, 1);
    chk("t6_writes", n_we, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
